// File: rtl/stream_demux_pkg.sv
// Shared definitions for the registered 1-to-N stream demultiplexer.
// The FSM states are only used when STREAM_DEMUX_PKT_LOCK_EN is defined.
package stream_demux_pkg;

  // Packet-routing states:
  // IDLE   - waiting for the first beat of a packet.
  // LOCKED - routing every beat to the latched channel.
  // DROP   - discarding the rest of a packet whose first beat had a bad select.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    LOCKED = 2'd1,
    DROP   = 2'd2
  } demux_state_t;

  // Low bit position of channel `ch` inside the flattened output data bus.
  function automatic int ch_offset(input int ch, input int data_w);
    return ch * data_w;
  endfunction

endpackage

// File: rtl/stream_demux_slot.sv
// Single-channel output holding register for stream_demux_1xn.
// Holds one beat. A load takes priority over a drain, so a simultaneous
// drain and load keeps the slot full with the new beat.
module stream_demux_slot #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [DATA_W-1:0] load_data,
  input  logic              out_ready,
  output logic              space,
  output logic [DATA_W-1:0] out_data,
  output logic              out_valid
);

  logic [DATA_W-1:0] data_p1;
  logic              vld_p1;
  logic              drain;

  // The slot drains when its consumer takes the held beat.
  assign drain = vld_p1 & out_ready;

  // The slot can take a new beat when empty or when it is draining this cycle.
  assign space = ~vld_p1 | out_ready;

  // ---- stage p1: output holding register ----
  // Load replaces the held beat; otherwise a drain empties the slot.
  // While full and stalled, data and valid are held unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_p1  <= 1'b0;
      data_p1 <= '0;
    end else if (load) begin
      vld_p1  <= 1'b1;
      data_p1 <= load_data;
    end else if (drain) begin
      vld_p1  <= 1'b0;
    end
  end

  assign out_data  = data_p1;
  assign out_valid = vld_p1;

endmodule

// File: rtl/stream_demux_1xn.sv
// Registered 1-to-N stream demultiplexer with a valid/ready handshake on
// every port and one holding register per output channel.
// Optional packet-lock mode: define STREAM_DEMUX_PKT_LOCK_EN to route whole
// packets (delimited by s_last) to the channel selected by the first beat.
// Without the macro every beat is routed by its own s_sel and s_last is unused.
module stream_demux_1xn
  import stream_demux_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int N_CH   = 4,
  parameter int SEL_W  = $clog2(N_CH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [DATA_W-1:0]        s_data,
  input  logic [SEL_W-1:0]         s_sel,
  input  logic                     s_valid,
  input  logic                     s_last,
  output logic                     s_ready,
  output logic [N_CH*DATA_W-1:0]   m_data,
  output logic [N_CH-1:0]          m_valid,
  input  logic [N_CH-1:0]          m_ready,
  output logic                     sel_err
);

  logic [SEL_W-1:0] route_sel;
  logic             route_hit;
  logic             sel_space;
  logic             drop_pkt;
  logic             accept;
  logic             sel_err_d;
  logic [N_CH-1:0]  slot_space;
  logic [N_CH-1:0]  slot_load;

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  demux_state_t     state_q;
  demux_state_t     state_d;
  logic [SEL_W-1:0] lock_sel;
  logic [SEL_W-1:0] lock_sel_d;

  // Inside a locked packet the latched channel overrides the beat's own select.
  always_comb begin
    route_sel = (state_q == LOCKED) ? lock_sel : s_sel;
    drop_pkt  = (state_q == DROP);
  end

  // Packet FSM: lock on the first beat, release on the beat carrying s_last.
  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel;
    case (state_q)
      IDLE: begin
        if (accept && !s_last) begin
          if (route_hit) begin
            state_d    = LOCKED;
            lock_sel_d = s_sel;
          end else begin
            state_d = DROP;
          end
        end
      end
      LOCKED: begin
        if (accept && s_last) state_d = IDLE;
      end
      DROP: begin
        if (accept && s_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Packet FSM state and latched channel.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      lock_sel <= '0;
    end else begin
      state_q  <= state_d;
      lock_sel <= lock_sel_d;
    end
  end
`else
  logic unused_last;

  assign unused_last = s_last;

  // Every beat is routed by its own select; nothing is ever packet-dropped.
  always_comb begin
    route_sel = s_sel;
    drop_pkt  = 1'b0;
  end
`endif

  // Decode the routed channel: range check and free space of the target slot.
  // An out-of-range select leaves sel_space at 1 so the beat is swallowed.
  always_comb begin
    route_hit = 1'b0;
    sel_space = 1'b1;
    for (int k = 0; k < N_CH; k++) begin
      if (route_sel == SEL_W'(k)) begin
        route_hit = 1'b1;
        sel_space = slot_space[k];
      end
    end
  end

  // s_ready depends only on the select path and the slot state, never on s_valid.
  assign s_ready   = drop_pkt | sel_space;
  assign accept    = s_valid & s_ready;
  assign sel_err_d = accept & ~drop_pkt & ~route_hit;

  // Error pulse for a dropped beat, visible the cycle after its accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sel_err <= 1'b0;
    end else begin
      sel_err <= sel_err_d;
    end
  end

  // One holding register per channel; each drains independently.
  for (genvar k = 0; k < N_CH; k++) begin : g_slot
    assign slot_load[k] = accept & ~drop_pkt & (route_sel == SEL_W'(k));

    stream_demux_slot #(
      .DATA_W(DATA_W)
    ) u_slot (
      .clk       (clk),
      .rst_n     (rst_n),
      .load      (slot_load[k]),
      .load_data (s_data),
      .out_ready (m_ready[k]),
      .space     (slot_space[k]),
      .out_data  (m_data[ch_offset(k, DATA_W) +: DATA_W]),
      .out_valid (m_valid[k])
    );
  end

endmodule

// File: tb/tb_stream_demux_1xn.sv
// Self-checking bench for stream_demux_1xn (N_CH=4 main instance plus an
// N_CH=3 instance for the out-of-range select case).
module tb_stream_demux_1xn;

  localparam int NCH = 4;

  logic        clk;
  logic        rst_n;
  logic [7:0]  s_data;
  logic [1:0]  s_sel;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [31:0] m_data;
  logic [3:0]  m_valid;
  logic [3:0]  m_ready;
  logic        sel_err;

  logic [7:0]  s3_data;
  logic [1:0]  s3_sel;
  logic        s3_valid;
  logic        s3_last;
  logic        s3_ready;
  logic [23:0] m3_data;
  logic [2:0]  m3_valid;
  logic [2:0]  m3_ready;
  logic        sel_err3;

  int errors = 0;
  int checks = 0;

  // Reference model: each channel holds at most one beat.
  bit         exp_full [NCH];
  logic [7:0] exp_dat  [NCH];
  bit         exp_err;
  int         mstate;   // 0 idle, 1 locked, 2 dropping
  int         mlock;

  stream_demux_1xn #(.DATA_W(8), .N_CH(4)) dut (
    .clk(clk), .rst_n(rst_n), .s_data(s_data), .s_sel(s_sel), .s_valid(s_valid),
    .s_last(s_last), .s_ready(s_ready), .m_data(m_data), .m_valid(m_valid),
    .m_ready(m_ready), .sel_err(sel_err)
  );

  stream_demux_1xn #(.DATA_W(8), .N_CH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .s_data(s3_data), .s_sel(s3_sel), .s_valid(s3_valid),
    .s_last(s3_last), .s_ready(s3_ready), .m_data(m3_data), .m_valid(m3_valid),
    .m_ready(m3_ready), .sel_err(sel_err3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_model();
    for (int k = 0; k < NCH; k++) begin
      exp_full[k] = 1'b0;
      exp_dat[k]  = 8'h00;
    end
    exp_err = 1'b0;
    mstate  = 0;
    mlock   = 0;
  endtask

  function automatic int model_route();
    if (mstate == 1) return mlock;
    return int'(s_sel);
  endfunction

  function automatic bit model_ready();
    int r;
    if (mstate == 2) return 1'b1;
    r = model_route();
    if (r >= NCH) return 1'b1;
    return !exp_full[r] || m_ready[r];
  endfunction

  function automatic logic [3:0] exp_mvalid();
    logic [3:0] v;
    for (int k = 0; k < NCH; k++) v[k] = exp_full[k];
    return v;
  endfunction

  // Advance one clock and apply the transfer rules to the model.
  task automatic tick();
    int r;
    bit acc;
    @(posedge clk);
    if (!rst_n) begin
      clear_model();
    end else begin
      r   = model_route();
      acc = s_valid && model_ready();
      for (int k = 0; k < NCH; k++)
        if (exp_full[k] && m_ready[k]) exp_full[k] = 1'b0;
      exp_err = 1'b0;
      if (acc) begin
        if (mstate == 2) begin
          if (s_last) mstate = 0;
        end else if (r >= NCH) begin
          exp_err = 1'b1;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
          if (!s_last) mstate = 2;
`endif
        end else begin
          exp_full[r] = 1'b1;
          exp_dat[r]  = s_data;
`ifdef STREAM_DEMUX_PKT_LOCK_EN
          if (mstate == 0 && !s_last) begin
            mstate = 1;
            mlock  = r;
          end else if (mstate == 1 && s_last) begin
            mstate = 0;
          end
`endif
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; s_valid = 1'b1; s_data = 8'hA5; s_sel = 2'd0; s_last = 1'b1;
    m_ready = 4'b0000;
    repeat (3) tick();
    checks++;
    if (m_valid !== 4'b0000) begin errors++; $display("FAIL reset_mvalid got=%b exp=%b", m_valid, 4'b0000); end
    checks++;
    if (m_data !== 32'h0) begin errors++; $display("FAIL reset_mdata got=%h exp=%h", m_data, 32'h0); end
    checks++;
    if (sel_err !== 1'b0) begin errors++; $display("FAIL reset_selerr got=%b exp=0", sel_err); end
    checks++;
    if (m3_valid !== 3'b000) begin errors++; $display("FAIL reset_m3valid got=%b exp=000", m3_valid); end
    rst_n = 1'b1; s_valid = 1'b0;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL reset_sready got=%b exp=1", s_ready); end
    tick();
  endtask

  task automatic test_basic_routing();
    m_ready = 4'b1111; s_last = 1'b1;
    for (int i = 0; i < NCH; i++) begin
      s_valid = 1'b1; s_sel = 2'(i); s_data = 8'h10 + 8'(i);
      #1;
      checks++;
      if (s_ready !== 1'b1) begin errors++; $display("FAIL route_sready ch=%0d got=%b exp=1", i, s_ready); end
      tick();
      checks++;
      if (m_valid !== (4'b0001 << i)) begin errors++; $display("FAIL route_mvalid ch=%0d got=%b exp=%b", i, m_valid, 4'b0001 << i); end
      checks++;
      if (m_data[i*8 +: 8] !== 8'h10 + 8'(i)) begin errors++; $display("FAIL route_mdata ch=%0d got=%h exp=%h", i, m_data[i*8 +: 8], 8'h10 + 8'(i)); end
    end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== 4'b0000) begin errors++; $display("FAIL route_drain got=%b exp=0000", m_valid); end
  endtask

  task automatic test_backpressure();
    m_ready = 4'b1011; s_last = 1'b1;
    s_valid = 1'b1; s_sel = 2'd2; s_data = 8'h22;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_first_sready got=%b exp=1", s_ready); end
    tick();
    s_data = 8'h33;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_stall_sready got=%b exp=0", s_ready); end
    repeat (2) tick();
    checks++;
    if (m_data[23:16] !== 8'h22 || m_valid[2] !== 1'b1) begin errors++; $display("FAIL bp_hold got=%h/%b exp=22/1", m_data[23:16], m_valid[2]); end
    s_sel = 2'd1; s_data = 8'h44;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_other_sready got=%b exp=1", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0110 || m_data[15:8] !== 8'h44) begin errors++; $display("FAIL bp_other got=%b/%h exp=0110/44", m_valid, m_data[15:8]); end
    s_sel = 2'd2; s_data = 8'h33;
    #1;
    checks++;
    if (s_ready !== 1'b0) begin errors++; $display("FAIL bp_restall_sready got=%b exp=0", s_ready); end
    m_ready = 4'b1111;
    #1;
    checks++;
    if (s_ready !== 1'b1) begin errors++; $display("FAIL bp_release_sready got=%b exp=1", s_ready); end
    tick();
    checks++;
    if (m_valid !== 4'b0100 || m_data[23:16] !== 8'h33) begin errors++; $display("FAIL bp_replace got=%b/%h exp=0100/33", m_valid, m_data[23:16]); end
    s_valid = 1'b0;
    tick();
    checks++;
    if (m_valid !== exp_mvalid()) begin errors++; $display("FAIL bp_final got=%b exp=%b", m_valid, exp_mvalid()); end
  endtask

  task automatic test_out_of_range();
    s3_valid = 1'b1; s3_sel = 2'd3; s3_data = 8'hFF; s3_last = 1'b1; m3_ready = 3'b000;
    #1;
    checks++;
    if (s3_ready !== 1'b1) begin errors++; $display("FAIL oor_sready got=%b exp=1", s3_ready); end
    tick();
    s3_valid = 1'b0;
    checks++;
    if (sel_err3 !== 1'b1) begin errors++; $display("FAIL oor_selerr got=%b exp=1", sel_err3); end
    checks++;
    if (m3_valid !== 3'b000) begin errors++; $display("FAIL oor_mvalid got=%b exp=000", m3_valid); end
    tick();
    checks++;
    if (sel_err3 !== 1'b0) begin errors++; $display("FAIL oor_selerr_clear got=%b exp=0", sel_err3); end
    s3_valid = 1'b1; s3_sel = 2'd2; s3_data = 8'h5A;
    tick();
    s3_valid = 1'b0;
    checks++;
    if (m3_valid !== 3'b100 || m3_data[23:16] !== 8'h5A || sel_err3 !== 1'b0) begin
      errors++; $display("FAIL oor_inrange got=%b/%h/%b exp=100/5a/0", m3_valid, m3_data[23:16], sel_err3);
    end
  endtask

  task automatic test_async_reset();
    m_ready = 4'b0000; s_last = 1'b1;
    s_valid = 1'b1; s_sel = 2'd0; s_data = 8'hC0;
    tick();
    s_sel = 2'd3; s_data = 8'hC3;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 4'b1001) begin errors++; $display("FAIL areset_fill got=%b exp=1001", m_valid); end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (m_valid !== 4'b0000) begin errors++; $display("FAIL areset_mvalid got=%b exp=0000", m_valid); end
    checks++;
    if (m_data !== 32'h0) begin errors++; $display("FAIL areset_mdata got=%h exp=0", m_data); end
    clear_model();
    #1;
    rst_n = 1'b1;
    tick();
  endtask

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  task automatic test_packet_lock();
    logic [1:0] sels [3];
    sels[0] = 2'd1; sels[1] = 2'd2; sels[2] = 2'd0;
    m_ready = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1; s_sel = sels[i]; s_data = 8'h51 + 8'(i); s_last = (i == 2);
      tick();
      checks++;
      if (m_valid !== 4'b0010 || m_data[15:8] !== 8'h51 + 8'(i)) begin
        errors++; $display("FAIL pkt_beat%0d got=%b/%h exp=0010/%h", i, m_valid, m_data[15:8], 8'h51 + 8'(i));
      end
    end
    s_sel = 2'd2; s_data = 8'h54; s_last = 1'b1;
    tick();
    s_valid = 1'b0;
    checks++;
    if (m_valid !== 4'b0100 || m_data[23:16] !== 8'h54) begin
      errors++; $display("FAIL pkt_after got=%b/%h exp=0100/54", m_valid, m_data[23:16]);
    end
    tick();
  endtask
`endif

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      s_valid = 1'($urandom_range(0, 3) != 0);
      s_sel   = 2'($urandom_range(0, 3));
      s_data  = 8'($urandom);
      s_last  = 1'($urandom_range(0, 2) == 0);
      m_ready = 4'($urandom);
      #1;
      checks++;
      if (s_ready !== model_ready()) begin errors++; $display("FAIL rand_sready n=%0d got=%b exp=%b", n, s_ready, model_ready()); end
      tick();
      checks++;
      if (m_valid !== exp_mvalid()) begin errors++; $display("FAIL rand_mvalid n=%0d got=%b exp=%b", n, m_valid, exp_mvalid()); end
      checks++;
      if (sel_err !== exp_err) begin errors++; $display("FAIL rand_selerr n=%0d got=%b exp=%b", n, sel_err, exp_err); end
      for (int k = 0; k < NCH; k++) begin
        if (exp_full[k]) begin
          checks++;
          if (m_data[k*8 +: 8] !== exp_dat[k]) begin errors++; $display("FAIL rand_mdata n=%0d ch=%0d got=%h exp=%h", n, k, m_data[k*8 +: 8], exp_dat[k]); end
        end
      end
    end
    s_valid = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_data = '0; s_sel = '0; s_last = 1'b1; m_ready = '0;
    s3_valid = 1'b0; s3_data = '0; s3_sel = '0; s3_last = 1'b1; m3_ready = '0;
    clear_model();
    test_reset();
    test_basic_routing();
    test_backpressure();
    test_out_of_range();
    test_async_reset();
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    test_packet_lock();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
